// File: rtl/systolic_array_ctrl_4_4.sv
// Job sequencer for the 4x4 weight-stationary systolic array: loads W from the top,
// streams skewed X columns from the left and captures skewed results from the bottom.
module systolic_array_ctrl_4_4 #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_N      = 4,
  parameter int ARRAY_LAT  = 4
) (
  input  logic                            ctrl_clk,
  input  logic                            ctrl_rst_n,
  input  logic                            ctrl_start,
  input  logic [2:0]                      ctrl_n_cols,
  input  logic [16*DATA_WIDTH-1:0]        ctrl_w_flat,
  input  logic [4*MAX_N*DATA_WIDTH-1:0]   ctrl_x_flat,
  output logic                            ctrl_busy,
  output logic                            ctrl_done,
  output logic [4*MAX_N*DATA_WIDTH-1:0]   ctrl_result,
  output logic [15:0]                     array_mode,
  output logic [3:0]                      array_en_up,
  output logic [4*DATA_WIDTH-1:0]         array_data_up,
  output logic [3:0]                      array_en_left,
  output logic [4*DATA_WIDTH-1:0]         array_data_left,
  input  logic [4*DATA_WIDTH-1:0]         array_data_down
);

  localparam int DW = DATA_WIDTH;
  localparam int NX = 4 * MAX_N;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMP, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [3:0]      k_q, k_d;
  logic [2:0]      n_q, n_d;
  logic [DW-1:0]   w_q [16];
  logic [DW-1:0]   w_d [16];
  logic [DW-1:0]   x_q [NX];
  logic [DW-1:0]   x_d [NX];
  logic [DW-1:0]   r_q [NX];
  logic [DW-1:0]   r_d [NX];

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [15:0]     mode_q, mode_d;
  logic [3:0]      en_up_q, en_up_d;
  logic [4*DW-1:0] data_up_q, data_up_d;
  logic [3:0]      en_left_q, en_left_d;
  logic [4*DW-1:0] data_left_q, data_left_d;

  always_comb begin : next_state
    state_d = state_q;
    k_d     = k_q + 4'd1;
    n_d     = n_q;
    w_d     = w_q;
    x_d     = x_q;
    r_d     = r_q;
    case (state_q)
      S_IDLE: begin
        k_d = '0;
        if (ctrl_start) begin
          state_d = S_LOAD;
          for (int i = 0; i < 16; i++) w_d[i] = ctrl_w_flat[i*DW +: DW];
          for (int i = 0; i < NX; i++) x_d[i] = ctrl_x_flat[i*DW +: DW];
          if (ctrl_n_cols == 3'd0)              n_d = 3'd1;
          else if (int'(ctrl_n_cols) > MAX_N)   n_d = 3'(MAX_N);
          else                                  n_d = ctrl_n_cols;
        end
      end
      S_LOAD: begin
        if (k_q == 4'd3) begin
          state_d = S_COMP;
          k_d     = '0;
        end
      end
      S_COMP: begin
        // Column c emits vector j at compute step ARRAY_LAT + j + c (diagonal skew).
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < MAX_N; j++) begin
            if (j < int'(n_q) && int'(k_q) == ARRAY_LAT + j + c)
              r_d[c*MAX_N + j] = array_data_down[c*DW +: DW];
          end
        end
        if (int'(k_q) == ARRAY_LAT + int'(n_q) + 2) begin
          state_d = S_DONE;
          k_d     = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registers line up with the state they describe.
  always_comb begin : next_outputs
    busy_d      = (state_d == S_LOAD) || (state_d == S_COMP);
    done_d      = (state_d == S_DONE);
    mode_d      = '0;
    en_up_d     = '0;
    data_up_d   = '0;
    en_left_d   = '0;
    data_left_d = '0;
    if (state_d == S_LOAD) begin
      mode_d  = '1;
      en_up_d = '1;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          if (int'(k_d) == 3 - r) data_up_d[c*DW +: DW] = w_d[r*4 + c];
        end
      end
    end
    if (state_d == S_COMP) begin
      if (int'(k_d) <= int'(n_d) + 2) en_left_d = '1;
      for (int r = 0; r < 4; r++) begin
        for (int j = 0; j < MAX_N; j++) begin
          if (j < int'(n_d) && int'(k_d) == r + j)
            data_left_d[r*DW +: DW] = x_d[r*MAX_N + j];
        end
      end
    end
  end

  always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      n_q         <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      for (int i = 0; i < NX; i++) begin
        x_q[i] <= '0;
        r_q[i] <= '0;
      end
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mode_q      <= '0;
      en_up_q     <= '0;
      data_up_q   <= '0;
      en_left_q   <= '0;
      data_left_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      w_q         <= w_d;
      x_q         <= x_d;
      r_q         <= r_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mode_q      <= mode_d;
      en_up_q     <= en_up_d;
      data_up_q   <= data_up_d;
      en_left_q   <= en_left_d;
      data_left_q <= data_left_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NX; i++) ctrl_result[i*DW +: DW] = r_q[i];
  end

  assign ctrl_busy       = busy_q;
  assign ctrl_done       = done_q;
  assign array_mode      = mode_q;
  assign array_en_up     = en_up_q;
  assign array_data_up   = data_up_q;
  assign array_en_left   = en_left_q;
  assign array_data_left = data_left_q;

endmodule

// File: tb/tb_systolic_array_ctrl_4_4.sv
// Bench for systolic_array_ctrl_4_4 driving a behavioural 4x4 weight-stationary array
// (weights shift down in mode 1; x flows right and partial sums flow down in mode 0).
module tb_systolic_array_ctrl_4_4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ctrl_start = 1'b0;
  logic [2:0]    ctrl_n_cols = '0;
  logic [511:0]  ctrl_w_flat = '0;
  logic [511:0]  ctrl_x_flat = '0;
  logic          ctrl_busy, ctrl_done;
  logic [511:0]  ctrl_result;
  logic [15:0]   array_mode;
  logic [3:0]    array_en_up, array_en_left;
  logic [127:0]  array_data_up, array_data_left, array_data_down;

  int tests_run = 0;
  int tests_failed = 0;

  systolic_array_ctrl_4_4 #(.DATA_WIDTH(32), .MAX_N(4), .ARRAY_LAT(4)) dut (
    .ctrl_clk(clk), .ctrl_rst_n(rst_n), .ctrl_start(ctrl_start), .ctrl_n_cols(ctrl_n_cols),
    .ctrl_w_flat(ctrl_w_flat), .ctrl_x_flat(ctrl_x_flat), .ctrl_busy(ctrl_busy),
    .ctrl_done(ctrl_done), .ctrl_result(ctrl_result), .array_mode(array_mode),
    .array_en_up(array_en_up), .array_data_up(array_data_up), .array_en_left(array_en_left),
    .array_data_left(array_data_left), .array_data_down(array_data_down)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural array ----------------
  logic signed [31:0] pw [4][4];
  logic signed [31:0] px [4][4];
  logic signed [31:0] ps [4][4];
  logic               pe [4][4];
  logic signed [31:0] w_in [4][4];
  logic signed [31:0] x_in [4][4];
  logic signed [31:0] s_in [4][4];
  logic               e_in [4][4];

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_in[0][c] = $signed(array_data_up[c*32 +: 32]);
      s_in[0][c] = 32'sd0;
      for (int r = 1; r < 4; r++) begin
        w_in[r][c] = pw[r-1][c];
        s_in[r][c] = ps[r-1][c];
      end
    end
    for (int r = 0; r < 4; r++) begin
      x_in[r][0] = $signed(array_data_left[r*32 +: 32]);
      e_in[r][0] = array_en_left[r];
      for (int c = 1; c < 4; c++) begin
        x_in[r][c] = px[r][c-1];
        e_in[r][c] = pe[r][c-1];
      end
    end
    for (int c = 0; c < 4; c++) array_data_down[c*32 +: 32] = ps[3][c];
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (array_mode[r*4 + c]) begin
          if (array_en_up[c]) pw[r][c] <= w_in[r][c];
        end else begin
          px[r][c] <= x_in[r][c];
          pe[r][c] <= e_in[r][c];
          ps[r][c] <= s_in[r][c] + (e_in[r][c] ? pw[r][c] * x_in[r][c] : 32'sd0);
        end
      end
    end
  end

  // ---------------- vectors (W/X index r*4+c, R index c*4+j) ----------------
  int w1  [16] = '{-1, 5, 9, 13,  2, -6, -10, 14,  3, 7, 11, 15,  4, 8, 12, -16};
  int x1  [16] = '{1, -2, 3, 0,  4, 5, 6, 0,  7, 8, 9, 0,  10, -11, 12, 0};
  int r1  [16] = '{68, -8, 84, 0,  110, -72, 138, 0,  166, -112, 210, 0,  14, 340, 66, 0};
  int wid [16] = '{1, 0, 0, 0,  0, 1, 0, 0,  0, 0, 1, 0,  0, 0, 0, 1};
  int xi  [16] = '{5, 50, 51, 52,  -6, 53, 54, 55,  7, 56, 57, 58,  -8, 59, 60, 61};
  int xa  [16] = '{1, 90, 91, 92,  2, 93, 94, 95,  3, 96, 97, 98,  4, 99, 100, 101};
  int xb  [16] = '{11, -12, 13, -14,  21, 22, -23, 24,  -31, 32, 33, 34,  41, 42, 43, -44};
  int wj  [16] = '{7, 7, 7, 7,  7, 7, 7, 7,  7, 7, 7, 7,  7, 7, 7, 7};

  // scoreboard: expected result bank and per-check expected queue
  int          exp_r [16];
  logic [31:0] exp_q [$];

  function automatic logic [511:0] pack16(input int a[16]);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'(a[i]);
    return v;
  endfunction

  task automatic apply_exp(input int res[16], input int n);
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < n; j++) exp_r[c*4 + j] = res[c*4 + j];
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input int w[16], input int x[16], input logic [2:0] n);
    ctrl_w_flat = pack16(w);
    ctrl_x_flat = pack16(x);
    ctrl_n_cols = n;
  endtask

  // Called in an IDLE cycle (#1 after an edge); returns accept-to-done cycles and ends in IDLE.
  task automatic run_job(input int w[16], input int x[16], input logic [2:0] n, output int lat);
    set_inputs(w, x, n);
    ctrl_start = 1'b1;
    lat = -1;
    for (int m = 1; m <= 40; m++) begin
      @(posedge clk); #1;
      ctrl_start = 1'b0;
      if (ctrl_done) begin
        lat = m;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({ctrl_busy, ctrl_done, array_mode, array_en_up, array_en_left} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got busy=%b done=%b mode=%h en_up=%h en_left=%h expected all 0",
               ctrl_busy, ctrl_done, array_mode, array_en_up, array_en_left);
    end
    tests_run++;
    if ({ctrl_result, array_data_up, array_data_left} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: result/data_up/data_left not zero (result=%h)", ctrl_result);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) exp_r[i] = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat;
    logic [31:0] e;
    run_job(w1, x1, 3'd3, lat);
    tests_run++;
    if (lat !== 15) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d expected 15", lat);
    end
    apply_exp(r1, 3);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(exp_r[i]));
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (ctrl_result[i*32 +: 32] !== e) begin
        tests_failed++;
        $display("FAIL basic_result[%0d]: got %0d expected %0d", i,
                 $signed(ctrl_result[i*32 +: 32]), $signed(e));
      end
    end
  endtask

  task automatic test_port_timing;
    logic [127:0] exp_up;
    logic [31:0]  exp_dl;
    logic [3:0]   exp_el;
    int k;
    set_inputs(w1, x1, 3'd3);
    ctrl_start = 1'b1;
    for (int m = 1; m <= 15; m++) begin
      @(posedge clk); #1;
      ctrl_start = 1'b0;
      if (m <= 4) begin
        for (int c = 0; c < 4; c++) exp_up[c*32 +: 32] = 32'(w1[(4 - m)*4 + c]);
        tests_run++;
        if (array_data_up !== exp_up || array_mode !== 16'hFFFF || array_en_up !== 4'hF) begin
          tests_failed++;
          $display("FAIL load_beat%0d: got up=%h mode=%h en_up=%h expected up=%h mode=ffff en_up=f",
                   m - 1, array_data_up, array_mode, array_en_up, exp_up);
        end
      end else if (m <= 14) begin
        k = m - 5;
        exp_dl = (k >= 2 && k <= 4) ? 32'(x1[8 + k - 2]) : 32'd0;
        exp_el = (k <= 5) ? 4'hF : 4'h0;
        tests_run++;
        if (array_data_left[64 +: 32] !== exp_dl || array_en_left !== exp_el ||
            array_mode !== 16'h0 || ctrl_busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL comp_k%0d: got left2=%0d en_left=%h mode=%h busy=%b expected left2=%0d en_left=%h mode=0 busy=1",
                   k, $signed(array_data_left[64 +: 32]), array_en_left, array_mode, ctrl_busy,
                   $signed(exp_dl), exp_el);
        end
      end else begin
        tests_run++;
        if (ctrl_done !== 1'b1 || ctrl_busy !== 1'b0 || array_en_left !== 4'h0) begin
          tests_failed++;
          $display("FAIL done_cycle: got done=%b busy=%b en_left=%h expected done=1 busy=0 en_left=0",
                   ctrl_done, ctrl_busy, array_en_left);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_identity_n1;
    int lat;
    logic [31:0] e;
    run_job(wid, xi, 3'd1, lat);
    tests_run++;
    if (lat !== 13) begin
      tests_failed++;
      $display("FAIL identity_latency: got %0d expected 13", lat);
    end
    apply_exp(xi, 1);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(exp_r[i]));
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (ctrl_result[i*32 +: 32] !== e) begin
        tests_failed++;
        $display("FAIL identity_result[%0d]: got %0d expected %0d", i,
                 $signed(ctrl_result[i*32 +: 32]), $signed(e));
      end
    end
  endtask

  task automatic test_clamp;
    int lat;
    logic [31:0] e;
    run_job(wid, xa, 3'd0, lat);
    tests_run++;
    if (lat !== 13) begin
      tests_failed++;
      $display("FAIL clamp0_latency: got %0d expected 13", lat);
    end
    apply_exp(xa, 1);
    run_job(wid, xb, 3'd7, lat);
    tests_run++;
    if (lat !== 16) begin
      tests_failed++;
      $display("FAIL clamp7_latency: got %0d expected 16", lat);
    end
    apply_exp(xb, 4);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(exp_r[i]));
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (ctrl_result[i*32 +: 32] !== e) begin
        tests_failed++;
        $display("FAIL clamp_result[%0d]: got %0d expected %0d", i,
                 $signed(ctrl_result[i*32 +: 32]), $signed(e));
      end
    end
  endtask

  task automatic test_ignore_start;
    int dones = 0;
    int first = -1;
    logic [31:0] e;
    set_inputs(w1, x1, 3'd3);
    ctrl_start = 1'b1;
    for (int m = 1; m <= 25; m++) begin
      @(posedge clk); #1;
      ctrl_start = 1'b0;
      if (ctrl_done) begin
        dones++;
        if (first < 0) first = m;
      end
      if (m == 2 || m == 8) begin
        set_inputs(wj, xb, 3'd1);
        ctrl_start = 1'b1;
      end
    end
    tests_run++;
    if (dones !== 1 || first !== 15) begin
      tests_failed++;
      $display("FAIL ignore_done: got %0d pulses first at %0d expected 1 pulse at 15", dones, first);
    end
    apply_exp(r1, 3);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(exp_r[i]));
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (ctrl_result[i*32 +: 32] !== e) begin
        tests_failed++;
        $display("FAIL ignore_result[%0d]: got %0d expected %0d", i,
                 $signed(ctrl_result[i*32 +: 32]), $signed(e));
      end
    end
  endtask

  task automatic test_reset_mid_job;
    int lat;
    logic [31:0] e;
    set_inputs(w1, x1, 3'd3);
    ctrl_start = 1'b1;
    for (int m = 1; m <= 8; m++) begin
      @(posedge clk); #1;
      ctrl_start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({ctrl_busy, ctrl_done, array_mode, array_en_up, array_en_left} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_ctrl: got busy=%b done=%b mode=%h en_up=%h en_left=%h expected all 0",
               ctrl_busy, ctrl_done, array_mode, array_en_up, array_en_left);
    end
    tests_run++;
    if ({ctrl_result, array_data_up, array_data_left} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_data: got result=%h left=%h expected 0", ctrl_result, array_data_left);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({ctrl_busy, ctrl_done, array_en_left, array_data_left} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_hold: got busy=%b done=%b en_left=%h expected 0",
               ctrl_busy, ctrl_done, array_en_left);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) exp_r[i] = 0;
    run_job(w1, x1, 3'd3, lat);
    tests_run++;
    if (lat !== 15) begin
      tests_failed++;
      $display("FAIL rerun_latency: got %0d expected 15", lat);
    end
    apply_exp(r1, 3);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(exp_r[i]));
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (ctrl_result[i*32 +: 32] !== e) begin
        tests_failed++;
        $display("FAIL rerun_result[%0d]: got %0d expected %0d", i,
                 $signed(ctrl_result[i*32 +: 32]), $signed(e));
      end
    end
  endtask

  task automatic test_back_to_back;
    int nd = 0;
    int at [3] = '{-1, -1, -1};
    logic [31:0] e;
    set_inputs(w1, x1, 3'd3);
    ctrl_start = 1'b1;
    for (int m = 1; m <= 60; m++) begin
      @(posedge clk); #1;
      if (ctrl_done) begin
        at[nd] = m;
        if (nd == 1) apply_exp(x1, 3);
        else         apply_exp(r1, 3);
        for (int i = 0; i < 16; i++) exp_q.push_back(32'(exp_r[i]));
        for (int i = 0; i < 16; i++) begin
          e = exp_q.pop_front();
          tests_run++;
          if (ctrl_result[i*32 +: 32] !== e) begin
            tests_failed++;
            $display("FAIL b2b_job%0d_result[%0d]: got %0d expected %0d", nd, i,
                     $signed(ctrl_result[i*32 +: 32]), $signed(e));
          end
        end
        nd++;
        if (nd == 1) set_inputs(wid, x1, 3'd3);
        else         set_inputs(w1, x1, 3'd3);
        if (nd == 3) begin
          ctrl_start = 1'b0;
          break;
        end
      end
    end
    ctrl_start = 1'b0;
    tests_run++;
    if (nd !== 3 || at[0] !== 15 || at[1] - at[0] !== 16 || at[2] - at[1] !== 16) begin
      tests_failed++;
      $display("FAIL b2b_spacing: got %0d jobs done at %0d,%0d,%0d expected 3 jobs at 15,31,47",
               nd, at[0], at[1], at[2]);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_port_timing();
    test_identity_n1();
    test_clamp();
    test_ignore_start();
    test_reset_mid_job();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/systolic_array_ctrl_4_4.md
Name: systolic_array_ctrl_4_4

Overview:
- Sequencer for the 4x4 weight-stationary systolic array (`systolic_array_4_4`).
- On a start request it latches one 4x4 weight matrix W and one 4xN input matrix X.
- It then loads W through the array's top ports (mode=1) and streams X into the left ports with a diagonal skew (mode=0).
- It captures the skewed results from the bottom ports into a result register bank, then pulses done.
- It sits between the NICE command/data path and the array, so software never has to hand-time array ports.

Parameters:
- DATA_WIDTH, 32: width of each signed element. Passed through; the controller does no arithmetic on data.
- MAX_N, 4: maximum number of X columns (vectors) per job.
- ARRAY_LAT, 4: compute cycle (counted from the first skewed left beat) at whose end the array's bottom row 0, vector 0 result is valid.

Ports:
- ctrl_clk  in  1  clock.
- ctrl_rst_n  in  1  asynchronous active-low reset.
- ctrl_start  in  1  job request; accepted only when ctrl_busy=0.
- ctrl_n_cols  in  3  number of X columns N, 1..MAX_N; sampled on accept.
- ctrl_w_flat  in  16*DATA_WIDTH  W; element W[r][c] at slice index r*4+c; sampled on accept.
- ctrl_x_flat  in  4*MAX_N*DATA_WIDTH  X; element X[r][j] at slice index r*MAX_N+j; sampled on accept.
- ctrl_busy  out  1  high from the accept cycle+1 until done.
- ctrl_done  out  1  one-cycle pulse; ctrl_result is valid from this cycle on.
- ctrl_result  out  4*MAX_N*DATA_WIDTH  R[c][j] at slice index c*MAX_N+j; held until the next accept.
- array_mode  out  16  per-PE mode, bit r*4+c → array_mode_r_c.
- array_en_up  out  4  bit c → array_en_up_0_c.
- array_data_up  out  4*DATA_WIDTH  slice c → array_data_up_0_c.
- array_en_left  out  4  bit r → array_en_left_r_0.
- array_data_left  out  4*DATA_WIDTH  slice r → array_data_left_r_0.
- array_data_down  in  4*DATA_WIDTH  slice c ← array_data_down_3_c.

Behaviour:
- **Reset:**
  - State is IDLE.
  - Every output register is 0: busy, done, result, mode, en_up, data_up, en_left, data_left.
  - Latched W, X and N are cleared.
- **Registered outputs:** all outputs are registered; array controls change only on a ctrl_clk rising edge.
- **States:** IDLE → LOAD → COMP → DONE → IDLE. A 4-bit step counter k is cleared on every state entry.
- **IDLE:**
  - Accept when ctrl_start=1. On accept, latch W, X and N; clamp N=0 to 1 and N>MAX_N to MAX_N.
  - Next state LOAD; busy=1 from the next cycle.
  - ctrl_result is not cleared on accept; it updates only by capture.
- **LOAD (k=0..3, 4 cycles):**
  - array_mode=all ones, array_en_up=4'hF, array_data_up[c]=W[3-k][c].
  - After the last beat, row r of the array holds W[r][c].
- **COMP (k=0..ARRAY_LAT+N+2):**
  - array_mode=0, array_en_up=0, array_data_up=0.
  - array_en_left = all ones for k ≤ N+2, else 0.
  - array_data_left[r] = X[r][k-r] when 0 ≤ k-r < N, else 0.
  - Capture: at the end of cycle k, for each c with j=k-ARRAY_LAT-c in 0..N-1, R[c][j] ← array_data_down[c].
  - Exit COMP after the last capture, which occurs at k=ARRAY_LAT+N+2.
- **DONE (1 cycle):**
  - done=1, busy=0, all array controls 0.
  - ctrl_start is ignored in this cycle; it can be accepted in the following IDLE cycle.
  - Minimum job-to-job spacing is 4+(ARRAY_LAT+N+3)+1+1 cycles.
- **ctrl_start while busy:** ignored, with no effect on the latched operands.
- **Result mapping:** the array computes R = Wᵀ·X, with R[c][j] = Σr W[r][c]·X[r][j]. Wrap/overflow is owned by the array; the controller passes data unchanged.
- **Reset mid-job:** immediate return to IDLE with every output at its reset value. The array contents are not guaranteed; the next job reloads W.
- **Job length:** total cycles from accept to done pulse = 1+4+(ARRAY_LAT+N+3). For N=3, ARRAY_LAT=4 this is 15.

Test Plan (bench instantiates systolic_array_4_4 + controller, DATA_WIDTH=32, MAX_N=4, N=3):
- W rows [-1,5,9,13],[2,-6,-10,14],[3,7,11,15],[4,8,12,-16]; X rows [1,-2,3],[4,5,6],[7,8,9],[10,-11,12] → R rows [68,-8,84],[110,-72,138],[166,-112,210],[14,340,66]; done exactly 15 cycles after accept.
- Same job, check port timing → array_data_up = W row 3,2,1,0 on LOAD beats 0..3; array_data_left[2] = 7 at COMP k=2, 8 at k=3, 9 at k=4, 0 elsewhere; array_en_left falls after k=5.
- W=identity, N=1, X column [5,-6,7,-8] → R column [5,-6,7,-8]; R columns 1..3 keep previous-job values; done 13 cycles after accept.
- Pulse ctrl_start with different W during LOAD and COMP → ignored; results equal the first job's results; one done pulse only.
- Assert ctrl_rst_n low during COMP k=3, then release and run the first job again → all outputs 0 while in reset; rerun produces the correct R.
- Back-to-back: ctrl_start held high continuously → jobs accepted on the IDLE cycles following each done; each result is correct; done pulses are spaced 16 cycles apart for N=3.
